// File: rtl/inst_rom_loader_pkg.sv
// Shared defines for the instruction ROM loader: bus widths, loader states, NOP word.
// Constants only; no logic, so there is no latency or backpressure.
package inst_rom_loader_pkg;

    localparam int INST_BUS_W         = 32;
    localparam int ADDR_BUS_W         = 32;
    localparam int DEFAULT_DEPTH_LOG2 = 10;

    localparam logic [INST_BUS_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/inst_rom_loader_if.sv
// CPU fetch port plus byte-stream image load port of the instruction ROM loader.
// Master is the CPU/host side; slave is the loader. load_ready_o paces the byte stream.
interface inst_rom_loader_if
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);
    logic                    rom_ce_i;
    logic [ADDR_BUS_W-1:0]   rom_addr_i;
    logic [INST_BUS_W-1:0]   rom_data_o;
    logic                    load_start_i;
    logic                    load_valid_i;
    logic [7:0]              load_byte_i;
    logic                    load_last_i;
    logic                    load_ready_o;
    logic                    cpu_hold_o;
    logic [DEPTH_LOG2:0]     words_loaded_o;
    logic                    overflow_o;

    modport master (
        output rom_ce_i, rom_addr_i, load_start_i, load_valid_i, load_byte_i, load_last_i,
        input  rom_data_o, load_ready_o, cpu_hold_o, words_loaded_o, overflow_o
    );

    modport slave (
        input  rom_ce_i, rom_addr_i, load_start_i, load_valid_i, load_byte_i, load_last_i,
        output rom_data_o, load_ready_o, cpu_hold_o, words_loaded_o, overflow_o
    );
endinterface

// File: rtl/inst_rom_loader_mem_array.sv
// Single-port word memory: write lands on the rising edge, read is combinational.
// No reset on contents; no backpressure.
module inst_mem_array
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [INST_BUS_W-1:0] wdata,
    output logic [INST_BUS_W-1:0] rdata
);

    logic [INST_BUS_W-1:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader: packs a big-endian byte stream into instruction memory, then serves CPU fetches.
// Fetch data is combinational in RUN; loader takes at most one byte per cycle while load_ready_o=1.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input logic              clk,
    input logic              rst,
    inst_rom_loader_if.slave bus
);

    localparam int unsigned          WORDS    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  WL_MAX   = WORDS[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2-1:0] ADDR_MAX = '1;

    loader_state_t           state_q;
    logic                    ready_q;
    logic                    hold_q;
    logic [DEPTH_LOG2-1:0]   wr_addr_q;
    logic [1:0]              byte_cnt_q;
    logic [INST_BUS_W-1:0]   word_q;
    logic [DEPTH_LOG2:0]     words_q;
    logic                    ovf_q;

    logic                    accept;
    logic                    word_done;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_addr;
    logic [INST_BUS_W-1:0]   mem_rdata;
    logic [INST_BUS_W-1:0]   wr_word;
    logic                    fetch_hit;
    logic                    unused_addr_lsb;

    // A start pulse outranks a coincident byte, so the byte is dropped.
    assign accept    = ready_q & bus.load_valid_i & ~bus.load_start_i;
    assign word_done = accept & ((byte_cnt_q == 2'd3) | bus.load_last_i);
    assign mem_we    = word_done & ~rst;

    // word_q keeps unfilled low bytes at zero, so a short final word is already padded.
    always_comb begin
        wr_word = word_q;
        case (byte_cnt_q)
            2'd0:    wr_word[31:24] = bus.load_byte_i;
            2'd1:    wr_word[23:16] = bus.load_byte_i;
            2'd2:    wr_word[15:8]  = bus.load_byte_i;
            default: wr_word[7:0]   = bus.load_byte_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            hold_q     <= 1'b1;
            wr_addr_q  <= '0;
            byte_cnt_q <= 2'd0;
            word_q     <= '0;
            words_q    <= '0;
            ovf_q      <= 1'b0;
        end else if (bus.load_start_i) begin
            state_q    <= LOAD;
            ready_q    <= 1'b1;
            hold_q     <= 1'b1;
            wr_addr_q  <= '0;
            byte_cnt_q <= 2'd0;
            word_q     <= '0;
            words_q    <= '0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_q     <= wr_word;
            if (word_done) begin
                byte_cnt_q <= 2'd0;
                word_q     <= '0;
                wr_addr_q  <= wr_addr_q + 1'b1;
                if (wr_addr_q == ADDR_MAX) begin
                    ovf_q <= 1'b1;
                end
                if (words_q != WL_MAX) begin
                    words_q <= words_q + 1'b1;
                end
            end
            if (bus.load_last_i) begin
                state_q <= RUN;
                ready_q <= 1'b0;
                hold_q  <= 1'b0;
            end
        end
    end

    // Writes only happen while loading and reads only matter in RUN, so one port suffices.
    assign mem_addr = ready_q ? wr_addr_q : bus.rom_addr_i[DEPTH_LOG2+1:2];

    inst_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wr_word),
        .rdata (mem_rdata)
    );

    assign fetch_hit = ~rst & (state_q == RUN) & bus.rom_ce_i &
                       (bus.rom_addr_i[ADDR_BUS_W-1:DEPTH_LOG2+2] == '0);
    assign unused_addr_lsb = ^bus.rom_addr_i[1:0];

    assign bus.rom_data_o     = fetch_hit ? mem_rdata : NOP_INST;
    assign bus.load_ready_o   = ready_q;
    assign bus.cpu_hold_o     = hold_q;
    assign bus.words_loaded_o = words_q;
    assign bus.overflow_o     = ovf_q;

endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words held (1024 words).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rom_ce_i  input  1  fetch enable from the CPU core.
REQ-005 SHALL have port rom_addr_i  input  32  CPU byte address, word-aligned.
REQ-006 SHALL have port rom_data_o  output  32  instruction returned to the CPU.
REQ-007 SHALL have port load_start_i  input  1  pulse that begins or restarts an image load.
REQ-008 SHALL have port load_valid_i  input  1  load byte valid.
REQ-009 SHALL have port load_byte_i  input  8  image byte, big-endian order within each word.
REQ-010 SHALL have port load_last_i  input  1  marks the final image byte; qualified by load_valid_i.
REQ-011 SHALL have port load_ready_o  output  1  loader accepts a byte this cycle.
REQ-012 SHALL have port cpu_hold_o  output  1  drives CPU reset while no valid image is present.
REQ-013 SHALL have port words_loaded_o  output  DEPTH_LOG2+1  number of words written by the current or last load.
REQ-014 SHALL have port overflow_o  output  1  sticky flag: image exceeded capacity.

Function
REQ-015 SHALL implement the states IDLE, LOAD and RUN.
REQ-016 SHALL transition IDLE->LOAD on load_start_i, RUN->LOAD on load_start_i, and LOAD->RUN on the cycle after an accepted byte with load_last_i=1.
REQ-017 SHALL, on entering or restarting LOAD, clear the write word address, the byte counter, the partial word, words_loaded_o and overflow_o.
REQ-018 SHALL drive load_ready_o=1 only in LOAD, so that a byte is accepted when load_valid_i and load_ready_o are both 1, at one byte per cycle maximum.
REQ-019 SHALL let load_start_i win if it coincides with load_valid_i in LOAD, so that the byte is dropped and any partial word is discarded.
REQ-020 SHALL ignore load_valid_i in IDLE and RUN.
REQ-021 SHALL place byte 0 of each word in bits 31:24, byte 1 in 23:16, byte 2 in 15:8 and byte 3 in 7:0.
REQ-022 SHALL write the assembled word to memory on the clock edge that accepts byte 3, then increment the write address and words_loaded_o.
REQ-023 SHALL, when load_last_i arrives on byte 0-2, write the partial word with the unfilled low bytes set to zero in that same cycle.
REQ-024 SHALL, when the write address wraps from 2^DEPTH_LOG2-1 to 0, set overflow_o; later words overwrite from address 0, and words_loaded_o saturates at 2^DEPTH_LOG2.
REQ-025 SHALL, in RUN, drive rom_data_o = mem[rom_addr_i[DEPTH_LOG2+1:2]] combinationally when rom_ce_i=1 and rom_addr_i[31:DEPTH_LOG2+2]=0, and 0 otherwise.
REQ-026 SHALL drive rom_data_o=0 (NOP) in IDLE and LOAD regardless of rom_ce_i.
REQ-027 SHALL drive cpu_hold_o=1 in IDLE and LOAD and 0 in RUN, registered from state, with no glitches.
REQ-028 SHALL ignore rom_addr_i[1:0].

Reset
REQ-029 SHALL, on rst=1, force state IDLE, load_ready_o=0, cpu_hold_o=1, rom_data_o=0, words_loaded_o=0, overflow_o=0 and clear the counters.
REQ-030 SHALL leave memory contents unaltered by reset, with no write occurring in a reset cycle.
REQ-031 SHALL let reset asserted mid-LOAD discard the partial word, while words already written remain.

Structure
REQ-032 SHALL place the state encoding, NOP constant (32'h0) and default DEPTH_LOG2 in the shared defines package, beside the existing instruction bus and address bus widths.
REQ-033 SHALL contain exactly one sub-module, inst_mem_array, a single-port memory with synchronous write and asynchronous read.

Verification
REQ-034 SHALL verify a basic load: load_start, then bytes 34 01 00 05 with last on the 4th -> mem[0]=32'h34010005, words_loaded_o=1, RUN one cycle later, cpu_hold_o=0, fetch addr 0 with ce=1 -> 32'h34010005.
REQ-035 SHALL verify partial-word padding: 6 bytes AA BB CC DD 11 22 with last on byte 6 -> mem[1]=32'h11220000, words_loaded_o=2.
REQ-036 SHALL verify restart: after 3 bytes, load_start together with load_valid -> byte dropped, new 4 bytes land at mem[0], words_loaded_o=1.
REQ-037 SHALL verify overflow with DEPTH_LOG2=2: 20 bytes -> overflow_o=1, mem[0] holds word 5, words_loaded_o=4.
REQ-038 SHALL verify fetch gating: in RUN, ce=0 -> 0; rom_addr_i=32'h0000_1000 with DEPTH_LOG2=10 -> 0; during LOAD any fetch -> 0.
REQ-039 SHALL verify reset mid-load: rst asserted after 6 bytes -> IDLE, cpu_hold_o=1, mem[0] retained, mem[1] unchanged.
